// File: rtl/count_seq_checker_if.sv
// rtl/count_seq_checker_if.sv - observed counter bus and checker status bundle
interface count_seq_checker_if #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
);
    logic              en;
    logic              cnt_rst;
    logic [WIDTH-1:0]  q_in;
    logic              locked;
    logic              err;
    logic [ERR_W-1:0]  err_count;
    logic [WRAP_W-1:0] wrap_count;
    logic [WIDTH-1:0]  exp_out;

    modport master (
        output en, cnt_rst, q_in,
        input  locked, err, err_count, wrap_count, exp_out
    );

    modport slave (
        input  en, cnt_rst, q_in,
        output locked, err, err_count, wrap_count, exp_out
    );
endinterface

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - checks an observed counter steps 0,1,..,2^WIDTH-1,0 with no skips or holds
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8,
    parameter int MISS_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    count_seq_checker_if.slave bus
);
    localparam int MISS_W = (MISS_MAX > 1) ? $clog2(MISS_MAX + 1) : 1;
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

    typedef enum logic [1:0] {IDLE, HOLD, ACQUIRE, TRACK} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              mismatch;
    logic              wrap_hit;

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        miss_d   = miss_q;
        mismatch = 1'b0;
        wrap_hit = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
            exp_d   = '0;
            miss_d  = '0;
        end else if (bus.cnt_rst) begin
            // A counter held in reset must read zero, whatever we expected before.
            mismatch = (state_q != IDLE) && (bus.q_in != '0);
            state_d  = HOLD;
            exp_d    = '0;
            miss_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                end
                HOLD: begin
                    mismatch = (bus.q_in != '0);
                    exp_d    = '0;
                    state_d  = ACQUIRE;
                end
                ACQUIRE: begin
                    exp_d   = bus.q_in + WIDTH'(1);
                    miss_d  = '0;
                    state_d = TRACK;
                end
                TRACK: begin
                    // Expected value keeps running on a miss so one glitch costs one error.
                    exp_d = exp_q + WIDTH'(1);
                    if (bus.q_in == exp_q) begin
                        miss_d   = '0;
                        wrap_hit = (exp_q == '0);
                    end else begin
                        mismatch = 1'b1;
                        if (miss_q == MISS_LAST) begin
                            miss_d  = '0;
                            state_d = ACQUIRE;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        locked_d   = (state_d == TRACK);
        err_d      = mismatch;
        err_cnt_d  = (mismatch && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
        wrap_cnt_d = (wrap_hit && (wrap_cnt_q != '1)) ? wrap_cnt_q + WRAP_W'(1) : wrap_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            exp_q      <= '0;
            miss_q     <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            miss_q     <= miss_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err        = err_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.wrap_count = wrap_cnt_q;
    assign bus.exp_out    = exp_q;
endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - randomized self-checking bench for count_seq_checker
module tb_count_seq_checker;
    localparam int MISS_MAX = 3;
    localparam int MODV     = 16;
    localparam int SAT      = 255;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    count_seq_checker_if #(.WIDTH(4), .ERR_W(8), .WRAP_W(8)) bif ();

    count_seq_checker #(.WIDTH(4), .ERR_W(8), .WRAP_W(8), .MISS_MAX(MISS_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] dut_vec;
    assign dut_vec = {bif.locked, bif.err, bif.err_count, bif.wrap_count, bif.exp_out};

    // Reference: "sync" is the next value the counter owes us, -1 when unknown.
    bit m_active, m_hold, m_err, m_locked;
    int m_sync, m_miss, m_errs, m_wraps, m_expout;

    function automatic logic [21:0] model_vec();
        return {m_locked, m_err, 8'(m_errs), 8'(m_wraps), 4'(m_expout)};
    endfunction

    task automatic model_reset();
        m_active = 0; m_hold = 0; m_err = 0; m_locked = 0;
        m_sync = -1; m_miss = 0; m_errs = 0; m_wraps = 0; m_expout = 0;
    endtask

    task automatic model_step(input bit e, input bit cr, input int q);
        m_err = 0;
        if (!e) begin
            m_active = 0; m_hold = 0; m_sync = -1; m_miss = 0; m_locked = 0; m_expout = 0;
        end else if (cr) begin
            m_err = m_active && (q != 0);
            m_active = 1; m_hold = 1; m_sync = -1; m_miss = 0; m_locked = 0; m_expout = 0;
        end else if (!m_active) begin
            m_active = 1; m_locked = 0;
        end else if (m_hold) begin
            m_err = (q != 0); m_hold = 0; m_locked = 0; m_expout = 0;
        end else if (m_sync < 0) begin
            m_sync = (q + 1) % MODV; m_expout = m_sync; m_miss = 0; m_locked = 1;
        end else begin
            if (q == m_sync) begin
                if (q == 0 && m_wraps < SAT) m_wraps++;
                m_miss = 0;
            end else begin
                m_err = 1; m_miss++;
            end
            m_sync = (m_sync + 1) % MODV;
            m_expout = m_sync;
            if (m_miss == MISS_MAX) begin
                m_sync = -1; m_miss = 0; m_locked = 0;
            end
        end
        if (m_err && m_errs < SAT) m_errs++;
    endtask

    task automatic step(input bit e, input bit cr, input int q);
        bif.en = e; bif.cnt_rst = cr; bif.q_in = 4'(q);
        @(posedge clk);
        model_step(e, cr, q);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; bif.en = 1'b0; bif.cnt_rst = 1'b0; bif.q_in = '0;
        model_reset();
        #7;
        reset = 1'b0;
    endtask

    task automatic lock();
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 1);
    endtask

    task automatic run_to_exp(input int target);
        for (int i = 0; i < 40 && m_expout != target; i++) step(1, 0, m_expout);
    endtask

    task automatic test_reset();
        reset = 1'b1; bif.en = 1'b1; bif.cnt_rst = 1'b0; bif.q_in = 4'd9;
        model_reset();
        #3;
        checks++;
        if (dut_vec !== 22'd0) begin
            errors++; $display("FAIL reset_state: got %h expected %h", dut_vec, 22'd0);
        end
        #4;
        reset = 1'b0;
    endtask

    task automatic test_acquire();
        bit cr_t [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
        int q_t  [8] = '{0, 0, 0, 1, 2, 3, 4, 5};
        bit lk_t [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, cr_t[i], q_t[i]);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL acquire_model step %0d: got %h expected %h", i, dut_vec, model_vec());
            end
            checks++;
            if (bif.locked !== lk_t[i] || bif.err !== 1'b0) begin
                errors++; $display("FAIL acquire_lock step %0d: got locked=%b err=%b expected locked=%b err=0", i, bif.locked, bif.err, lk_t[i]);
            end
        end
        checks++;
        if (bif.exp_out !== 4'd6) begin
            errors++; $display("FAIL acquire_exp: got %0d expected 6", bif.exp_out);
        end
    endtask

    task automatic test_free_run();
        do_reset();
        step(1, 1, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 0, i % MODV);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL free_run step %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (bif.wrap_count !== 8'd2 || bif.err_count !== 8'd0) begin
            errors++; $display("FAIL free_run_counts: got wrap=%0d err=%0d expected wrap=2 err=0", bif.wrap_count, bif.err_count);
        end
        for (int i = 40; i < 40 + 16 * 260; i++) step(1, 0, i % MODV);
        checks++;
        if (bif.wrap_count !== 8'd255 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL wrap_saturate: got %h expected %h (wrap=255)", dut_vec, model_vec());
        end
    endtask

    task automatic test_glitch();
        int q_t   [3] = '{9, 6, 7};
        bit err_t [3] = '{1, 0, 0};
        do_reset();
        lock();
        run_to_exp(5);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, q_t[i]);
            checks++;
            if (bif.err !== err_t[i] || bif.locked !== 1'b1 || dut_vec !== model_vec()) begin
                errors++; $display("FAIL glitch step %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (bif.err_count !== 8'd1) begin
            errors++; $display("FAIL glitch_count: got %0d expected 1", bif.err_count);
        end
    endtask

    task automatic test_stuck();
        bit err_t [4] = '{1, 1, 1, 0};
        bit lk_t  [4] = '{1, 1, 0, 1};
        do_reset();
        lock();
        run_to_exp(8);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 3);
            checks++;
            if (bif.err !== err_t[i] || bif.locked !== lk_t[i] || dut_vec !== model_vec()) begin
                errors++; $display("FAIL stuck step %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (bif.err_count !== 8'd3 || bif.exp_out !== 4'd4) begin
            errors++; $display("FAIL stuck_count: got err=%0d exp=%0d expected err=3 exp=4", bif.err_count, bif.exp_out);
        end
    endtask

    task automatic test_cnt_rst_mid();
        do_reset();
        lock();
        run_to_exp(7);
        step(1, 1, 7);
        checks++;
        if (bif.err !== 1'b1 || bif.locked !== 1'b0 || bif.exp_out !== 4'd0) begin
            errors++; $display("FAIL cnt_rst_mid: got err=%b locked=%b exp=%0d expected 1 0 0", bif.err, bif.locked, bif.exp_out);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, i < 2, 0);
            checks++;
            if (bif.err !== 1'b0 || dut_vec !== model_vec()) begin
                errors++; $display("FAIL cnt_rst_hold step %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_random();
        int  cq;
        bit  e, cr;
        int  q;
        do_reset();
        cq = 0;
        for (int i = 0; i < 600; i++) begin
            e  = ($urandom_range(0, 19) != 0);
            cr = ($urandom_range(0, 14) == 0);
            q  = ($urandom_range(0, 99) < 85) ? cq : int'($urandom_range(0, MODV - 1));
            step(e, cr, q);
            cq = cr ? 0 : (cq + 1) % MODV;
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL random step %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_err_saturation();
        do_reset();
        step(1, 1, 0);
        for (int i = 0; i < 300; i++) begin
            step(1, 1, 5);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL err_sat step %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (bif.err_count !== 8'd255) begin
            errors++; $display("FAIL err_saturate: got %0d expected 255", bif.err_count);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0);
        step(1, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 22'd0) begin
            errors++; $display("FAIL async_reset: got %h expected %h", dut_vec, 22'd0);
        end
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 4 + i);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL after_reset step %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_acquire();
        test_free_run();
        test_glitch();
        test_stuck();
        test_cnt_rst_mid();
        test_random();
        test_err_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
